// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx: I2S master receiver for one MEMS mic; captures one slot, truncates and
// box-averages REDUCE_FACTOR samples into a pcm_out/pcm_ready strobe.
module i2s_mic_rx #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int I2S_CLK_FREQ  = 1_500_000,
  parameter int I2S_DATA_SIZE = 24,
  parameter int DATA_OUT_SIZE = 16,
  parameter int REDUCE_FACTOR = 2,
  parameter int CHANNEL       = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     i2s_clk,
  output logic                     i2s_ws,
  input  logic                     i2s_sd,
  output logic [DATA_OUT_SIZE-1:0] pcm_out,
  output logic                     pcm_ready
);
  localparam int HD = (CLK_FREQ / (2 * I2S_CLK_FREQ)) > 1 ? CLK_FREQ / (2 * I2S_CLK_FREQ) : 1;
  localparam int DW = HD > 1 ? $clog2(HD) : 1;
  localparam int LR = $clog2(REDUCE_FACTOR);
  localparam int CW = LR > 0 ? LR : 1;
  localparam int DO = DATA_OUT_SIZE;
  localparam int DS = I2S_DATA_SIZE;
  localparam int AW = DO + LR;

  logic [DW-1:0] div_q, div_d;
  logic sck_q, sck_d, ws_q, ws_d, armed_q, armed_d, rdy_q, rdy_d;
  logic [5:0] bit_q, bit_d;
  logic [DO-1:0] sh_q, sh_d, pcm_q, pcm_d;
  logic signed [AW-1:0] acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick, rise, fall, cap, done, last;
  logic [4:0] k;

  // Only the top DO slot bits are kept; later data bits are the truncated LSBs.
  always_comb begin
    tick    = div_q == DW'(HD - 1);
    rise    = tick & ~sck_q;
    fall    = tick & sck_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    sck_d   = sck_q ^ tick;
    bit_d   = bit_q + {5'd0, fall};
    ws_d    = fall ? bit_d[5] : ws_q;
    armed_d = armed_q | (fall & (bit_q == 6'd63));
    k       = bit_q[4:0];
    cap     = rise & armed_q & (bit_q[5] == 1'(CHANNEL));
    sh_d    = (cap && k >= 5'd1 && k <= 5'(DO)) ? {sh_q[DO-2:0], i2s_sd} : sh_q;
    done    = cap && k == 5'(DS);
    sum     = acc_q + AW'($signed(sh_d));
    last    = cnt_q == CW'(REDUCE_FACTOR - 1);
    acc_d   = done ? (last ? '0 : sum) : acc_q;
    cnt_d   = done ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    rdy_d   = done & last;
    pcm_d   = rdy_d ? DO'(sum >>> LR) : pcm_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      armed_q <= 1'b0;
      rdy_q   <= 1'b0;
      bit_q   <= '0;
      sh_q    <= '0;
      pcm_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      div_q   <= div_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      armed_q <= armed_d;
      rdy_q   <= rdy_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      pcm_q   <= pcm_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign i2s_clk   = sck_q;
  assign i2s_ws    = ws_q;
  assign pcm_out   = pcm_q;
  assign pcm_ready = rdy_q;
endmodule

// File: tb/tb_i2s_mic_rx.sv
// tb_i2s_mic_rx: three configurations (default, RF=1 left at HALF_DIV=2, RF=1 right at
// HALF_DIV=1) driven by a per-frame microphone model and checked against arithmetic averages.
module tb_i2s_mic_rx;
  localparam int NF = 16;
  localparam int RF[3] = '{2, 1, 1};
  localparam int CH[3] = '{0, 0, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck[3], ws[3], sd[3], rdy[3], prev_rdy[3], prev_sck[3];
  logic [15:0] pcm[3], hold[3];
  int lw[3][NF], rw[3][NF];
  int nf[3], g[3];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  i2s_mic_rx d0 (.clk(clk), .rst_n(rst_n), .i2s_clk(sck[0]), .i2s_ws(ws[0]), .i2s_sd(sd[0]),
                 .pcm_out(pcm[0]), .pcm_ready(rdy[0]));
  i2s_mic_rx #(.I2S_CLK_FREQ(25_000_000), .REDUCE_FACTOR(1)) d1 (
    .clk(clk), .rst_n(rst_n), .i2s_clk(sck[1]), .i2s_ws(ws[1]), .i2s_sd(sd[1]),
    .pcm_out(pcm[1]), .pcm_ready(rdy[1]));
  i2s_mic_rx #(.I2S_CLK_FREQ(50_000_000), .REDUCE_FACTOR(1), .CHANNEL(1)) d2 (
    .clk(clk), .rst_n(rst_n), .i2s_clk(sck[2]), .i2s_ws(ws[2]), .i2s_sd(sd[2]),
    .pcm_out(pcm[2]), .pcm_ready(rdy[2]));

  // Mic output for the position reached after n falling edges; junk outside the data bits.
  function automatic logic mic_bit(int i, int n);
    int p = n % 64;
    int f = (n / 64) % NF;
    int k = p % 32;
    logic [23:0] w = 24'(p >= 32 ? rw[i][f] : lw[i][f]);
    return (k >= 1 && k <= 24) ? w[24-k] : 1'(n % 3 == 0);
  endfunction

  function automatic int fdiv(int a, int b);
    int q = a / b;
    if (a % b != 0 && a < 0) q--;
    return q;
  endfunction

  function automatic logic [15:0] exp_pcm(int i, int gi);
    int s = 0;
    for (int j = 0; j < RF[i]; j++) begin
      int f = (1 + gi * RF[i] + j) % NF;
      int w = CH[i] != 0 ? rw[i][f] : lw[i][f];
      int v = w >= 32'h800000 ? w - 32'h1000000 : w;
      s += fdiv(v, 256);
    end
    return 16'(fdiv(s, RF[i]));
  endfunction

  always @(negedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        nf[i] <= 0;
        sd[i] <= 1'b0;
        prev_sck[i] <= 1'b0;
      end else begin
        if (prev_sck[i] && !sck[i]) begin
          nf[i] <= nf[i] + 1;
          sd[i] <= mic_bit(i, nf[i] + 1);
        end
        prev_sck[i] <= sck[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ws%0d", i), 32'(ws[i]), 32'((nf[i] % 64) >= 32));
      if (rdy[i] === 1'b1) begin
        logic [15:0] e = exp_pcm(i, g[i]);
        check($sformatf("pcm%0d_g%0d", i, g[i]), 32'(pcm[i]), 32'(e));
        check($sformatf("when%0d_g%0d", i, g[i]), nf[i], (g[i] * RF[i] + RF[i]) * 64 + CH[i] * 32 + 24);
        check($sformatf("width%0d", i), 32'(prev_rdy[i]), 32'(0));
        hold[i] = e;
        g[i]++;
      end else begin
        check($sformatf("hold%0d", i), 32'(pcm[i]), 32'(hold[i]));
      end
      prev_rdy[i] = rdy[i];
    end
  endtask

  task automatic wait_g(input int i, input int n);
    int c = 0;
    while (g[i] < n && c < 20000) begin
      step();
      c++;
    end
    check($sformatf("timeout_g%0d_%0d", i, n), 32'(g[i] >= n), 32'(1));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      g[i] = 0;
      hold[i] = '0;
      prev_rdy[i] = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s%0d", tag, i), {sck[i], ws[i], rdy[i], pcm[i]}, 32'(0));
  endtask

  initial begin
    int c;
    logic seen0;
    for (int i = 0; i < 3; i++)
      for (int f = 0; f < NF; f++) begin
        lw[i][f] = int'($urandom & 32'hFFFFFF);
        rw[i][f] = int'($urandom & 32'hFFFFFF);
      end
    lw[0][1] = 32'h001000; lw[0][2] = 32'h003000;
    lw[0][3] = 32'hFFFF00; lw[0][4] = 32'h000100;
    lw[0][5] = 32'hFFFF00; lw[0][6] = 32'hFFFE00;
    lw[1][1] = 32'h7FFFFF; rw[1][1] = 32'h123456; lw[1][2] = 32'h800000;
    lw[2][1] = 32'h111111; rw[2][1] = 32'h654321;
    clear_model();
    repeat (3) step();
    check_zero("rst_out");
    rst_n = 1'b1;
    c = 0;
    while (sck[0] !== 1'b1 && c < 100) begin
      step();
      c++;
    end
    check("first_rise", c, 33);
    c = 0;
    seen0 = 1'b0;
    while (c < 200) begin
      step();
      c++;
      if (sck[0] === 1'b0) seen0 = 1'b1;
      if (seen0 && sck[0] === 1'b1) break;
    end
    check("sck_period", c, 66);
    wait_g(2, 1);
    check("right_only", 32'(pcm[2]), 32'h6543);
    wait_g(1, 1);
    check("max_pos", 32'(pcm[1]), 32'h7FFF);
    wait_g(1, 2);
    check("max_neg", 32'(pcm[1]), 32'h8000);
    wait_g(0, 1);
    check("avg_pos", 32'(pcm[0]), 32'h0020);
    wait_g(0, 2);
    check("avg_zero", 32'(pcm[0]), 32'h0000);
    wait_g(0, 3);
    check("avg_floor", 32'(pcm[0]), 32'hFFFE);
    c = 0;
    while (nf[0] != 7 * 64 + 10 && c < 20000) begin
      step();
      c++;
    end
    check("reach_bit10", nf[0], 7 * 64 + 10);
    rst_n = 1'b0;
    #1;
    check_zero("midrst_out");
    clear_model();
    repeat (3) step();
    rst_n = 1'b1;
    wait_g(0, 1);
    check("restart_avg", 32'(pcm[0]), 32'h0020);
    check("d1_rate", 32'(g[1] >= 30), 32'(1));
    check("d2_rate", 32'(g[2] >= 60), 32'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
